// File: rtl/debounce_array.sv
//==============================================================================
// Module   : debounce_array
// Purpose  : Multi-channel button synchroniser/debouncer with press/release
//            pulses, long-press detection and auto-repeat.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module debounce_array #(
  parameter int N_CH          = 4,
  parameter int DELAY_COUNTS  = 2500,
  parameter int HOLD_COUNTS   = 25_000_000,
  parameter int REPEAT_COUNTS = 5_000_000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] pressed,
  output logic [N_CH-1:0] released,
  output logic [N_CH-1:0] held,
  output logic [N_CH-1:0] repeat_pulse
);

  localparam int c_cnt_w  = $clog2(DELAY_COUNTS + 1);
  localparam int c_hcnt_w = (HOLD_COUNTS > 1) ? $clog2(HOLD_COUNTS) : 1;
  localparam int c_rcnt_w = (REPEAT_COUNTS > 1) ? $clog2(REPEAT_COUNTS) : 1;

  localparam logic [c_cnt_w-1:0]  c_delay     = c_cnt_w'(DELAY_COUNTS);
  localparam logic [c_hcnt_w-1:0] c_hold_last = c_hcnt_w'(HOLD_COUNTS - 1);
  localparam logic [c_rcnt_w-1:0] c_rep_last  =
      c_rcnt_w'((REPEAT_COUNTS > 0) ? (REPEAT_COUNTS - 1) : 0);
  localparam bit                  c_rep_en    = (REPEAT_COUNTS > 0);

  // Normalise polarity so that 1 always means pressed from here on.
  logic [N_CH-1:0] w_b;
  assign w_b = ACTIVE_LOW ? ~button : button;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic                r_sync1;
    logic                r_sync2;
    logic                r_prev;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_level;
    logic                r_pressed;
    logic                r_released;
    logic [c_hcnt_w-1:0] r_hcnt;
    logic                r_held;
    logic [c_rcnt_w-1:0] r_rcnt;
    logic                r_rep;
    logic                w_stable;
    logic                w_fall;

    assign w_stable = (r_sync2 == r_prev) && (r_cnt == c_delay);
    assign w_fall   = w_stable && !r_prev && r_level;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= w_b[i];
        r_sync2 <= r_sync1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_prev     <= 1'b0;
        r_cnt      <= '0;
        r_level    <= 1'b0;
        r_pressed  <= 1'b0;
        r_released <= 1'b0;
      end else begin
        if (r_sync2 != r_prev) begin
          r_prev <= r_sync2;
          r_cnt  <= '0;
        end else if (r_cnt != c_delay) begin
          r_cnt <= r_cnt + 1'b1;
        end
        r_pressed  <= 1'b0;
        r_released <= 1'b0;
        if (w_stable) begin
          r_level    <= r_prev;
          r_pressed  <= r_prev & ~r_level;
          r_released <= ~r_prev & r_level;
        end
      end
    end

    // The releasing edge must win over any hold/repeat activity in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_hcnt <= '0;
        r_held <= 1'b0;
        r_rcnt <= '0;
        r_rep  <= 1'b0;
      end else begin
        r_rep <= 1'b0;
        if (w_fall || !r_level) begin
          r_hcnt <= '0;
          r_held <= 1'b0;
          r_rcnt <= '0;
        end else if (!r_held) begin
          if (r_hcnt == c_hold_last) begin
            r_held <= 1'b1;
            r_rep  <= 1'b1;
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end else if (c_rep_en) begin
          if (r_rcnt == c_rep_last) begin
            r_rcnt <= '0;
            r_rep  <= 1'b1;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end
      end
    end

    assign level[i]        = r_level;
    assign pressed[i]      = r_pressed;
    assign released[i]     = r_released;
    assign held[i]         = r_held;
    assign repeat_pulse[i] = r_rep;
  end

endmodule

`default_nettype wire

// File: tb/tb_debounce_array.sv
//==============================================================================
// Module   : tb_debounce_array
// Purpose  : Self-checking bench for debounce_array against a window/age model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_debounce_array;

  localparam int TB_N = 2;
  localparam int TB_D = 4;
  localparam int TB_H = 10;
  localparam int TB_R = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [TB_N-1:0] button;
  logic [TB_N-1:0] level;
  logic [TB_N-1:0] pressed;
  logic [TB_N-1:0] released;
  logic [TB_N-1:0] held;
  logic [TB_N-1:0] repeat_pulse;

  int checks   = 0;
  int failures = 0;

  // Reference model: level follows a value once the last D+2 synchronised
  // samples agree; hold/repeat derive from the age of the current press.
  logic [TB_D+3:0] hist [TB_N];
  logic [TB_N-1:0] m_level, m_pressed, m_released, m_held, m_rep;
  int              age  [TB_N];

  debounce_array #(
    .N_CH          (TB_N),
    .DELAY_COUNTS  (TB_D),
    .HOLD_COUNTS   (TB_H),
    .REPEAT_COUNTS (TB_R),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .button       (button),
    .level        (level),
    .pressed      (pressed),
    .released     (released),
    .held         (held),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [TB_N-1:0] obs, input logic [TB_N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < TB_N; c++) begin
      hist[c] = '0;
      age[c]  = 0;
    end
    m_level = '0; m_pressed = '0; m_released = '0; m_held = '0; m_rep = '0;
  endtask

  task automatic model_edge(input logic [TB_N-1:0] btn);
    for (int c = 0; c < TB_N; c++) begin
      logic old_l, new_l, all1, all0;
      hist[c] = {hist[c][TB_D+2:0], ~btn[c]};
      all1 = 1'b1;
      all0 = 1'b1;
      for (int k = 2; k <= TB_D + 3; k++) begin
        if (hist[c][k]) all0 = 1'b0;
        else            all1 = 1'b0;
      end
      old_l = m_level[c];
      new_l = all1 ? 1'b1 : (all0 ? 1'b0 : old_l);
      m_pressed[c]  = new_l & ~old_l;
      m_released[c] = ~new_l & old_l;
      if (!new_l || !old_l) age[c] = 0;
      else                  age[c] = age[c] + 1;
      m_held[c]  = new_l && (age[c] >= TB_H);
      m_rep[c]   = m_held[c] && (((age[c] - TB_H) % TB_R) == 0);
      m_level[c] = new_l;
    end
  endtask

  task automatic check_model();
    chk("level",        level,        m_level);
    chk("pressed",      pressed,      m_pressed);
    chk("released",     released,     m_released);
    chk("held",         held,         m_held);
    chk("repeat_pulse", repeat_pulse, m_rep);
  endtask

  task automatic cycle(input logic [TB_N-1:0] btn);
    button = btn;
    @(posedge clk);
    if (rst_n) model_edge(btn);
    else       model_reset();
    #1;
    check_model();
  endtask

  // Assert reset mid-cycle, check the outputs clear before the next edge.
  task automatic async_reset(input int n);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_level", level, 2'b00);
    chk("async_rst_held",  held,  2'b00);
    check_model();
    repeat (n) cycle(button);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [TB_N-1:0] rb;
    logic            g0;
    rst_n  = 1'b0;
    button = 2'b00;
    model_reset();

    // Reset held with both buttons pressed
    repeat (20) cycle(2'b00);
    button = 2'b11;
    rst_n  = 1'b1;
    repeat (10) cycle(2'b11);

    // Clean press, long press, release at edge 30
    for (int e = 0; e <= 45; e++) begin
      cycle((e < 30) ? 2'b10 : 2'b11);
      chk("lp_level",    level,        {1'b0, (e >= 7 && e < 37)});
      chk("lp_pressed",  pressed,      {1'b0, (e == 7)});
      chk("lp_released", released,     {1'b0, (e == 37)});
      chk("lp_held",     held,         {1'b0, (e >= 17 && e < 37)});
      chk("lp_repeat",   repeat_pulse, {1'b0, (e >= 17 && e < 37 && ((e - 17) % 3) == 0)});
    end
    repeat (10) cycle(2'b11);

    // Bounce every 3 cycles, then stable press
    for (int e = 0; e < 30; e++) begin
      cycle(((e / 3) % 2 == 0) ? 2'b10 : 2'b11);
      chk("bounce_level", level, 2'b00);
    end
    for (int e = 0; e <= 8; e++) begin
      cycle(2'b10);
      chk("settle_level", level, {1'b0, (e >= 7)});
    end
    repeat (12) cycle(2'b11);

    // Simultaneous press; channel 1 releases at edge 12
    for (int e = 0; e <= 25; e++) begin
      cycle({(e >= 12), 1'b0});
      if (e == 7)  chk("sim_pressed",  pressed,  2'b11);
      if (e == 19) chk("sim_released", released, 2'b10);
      chk("sim_held0",   {1'b0, held[0]},         {1'b0, (e >= 17)});
      chk("sim_repeat0", {1'b0, repeat_pulse[0]}, {1'b0, (e == 17 || e == 20 || e == 23)});
    end

    // Reset mid-hold with channel 0 still pressed
    button = 2'b10;
    async_reset(2);
    for (int e = 0; e <= 18; e++) begin
      cycle(2'b10);
      chk("rh_level0",   {1'b0, level[0]},   {1'b0, (e >= 7)});
      chk("rh_pressed0", {1'b0, pressed[0]}, {1'b0, (e == 7)});
      chk("rh_held0",    {1'b0, held[0]},    {1'b0, (e >= 17)});
    end

    // Short glitch while held leaves level/held alone
    for (int e = 0; e < 13; e++) begin
      g0 = (e >= 2 && e < 5);
      cycle({1'b1, g0});
      chk("glitch_level", level, 2'b01);
      chk("glitch_held",  held,  2'b01);
    end
    repeat (12) cycle(2'b11);

    // Randomised activity with occasional asynchronous resets
    rb = 2'b11;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < TB_N; c++)
        if ($urandom_range(0, 11) == 0) rb[c] = ~rb[c];
      cycle(rb);
      if ($urandom_range(0, 299) == 0) async_reset(int'($urandom_range(1, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
